// File: rtl/apb_arbiter_2to1.sv
// rtl/apb_arbiter_2to1.sv - two-requester round-robin APB arbiter with per-transfer timeout
`timescale 1ns/1ps
module apb_arbiter_2to1 #(
    parameter int G_ADDR_WIDTH = 4,
    parameter int G_TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s0_apb_psel,
    input  logic                    s0_apb_penable,
    input  logic                    s0_apb_pwrite,
    input  logic [2:0]              s0_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0] s0_apb_paddr,
    input  logic [31:0]             s0_apb_pwdata,
    input  logic [3:0]              s0_apb_pstrb,
    output logic                    s0_apb_pready,
    output logic [31:0]             s0_apb_prdata,
    output logic                    s0_apb_pslverr,
    input  logic                    s1_apb_psel,
    input  logic                    s1_apb_penable,
    input  logic                    s1_apb_pwrite,
    input  logic [2:0]              s1_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0] s1_apb_paddr,
    input  logic [31:0]             s1_apb_pwdata,
    input  logic [3:0]              s1_apb_pstrb,
    output logic                    s1_apb_pready,
    output logic [31:0]             s1_apb_prdata,
    output logic                    s1_apb_pslverr,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [31:0]             m_apb_pwdata,
    output logic [3:0]              m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic                    m_apb_pslverr,
    input  logic [31:0]             m_apb_prdata
);
    localparam int CW = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (G_TIMEOUT > 0) ? CW'(G_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t                  state, state_nxt;
    logic                    last_grant;
    logic                    lat_pwrite;
    logic [2:0]              lat_pprot;
    logic [G_ADDR_WIDTH-1:0] lat_paddr;
    logic [31:0]             lat_pwdata;
    logic [3:0]              lat_pstrb;
    logic [31:0]             rsp_prdata;
    logic                    rsp_pslverr;
    logic [CW-1:0]           to_cnt;

    logic grant_sel, do_grant, do_capture, do_timeout, rsp_fire;
    logic g_psel, g_penable, timeout_hit, m_active;

    // Next-state decode: arbitration in IDLE, completion/timeout in ACCESS, upstream handback in RESP
    always_comb begin
        grant_sel   = (s0_apb_psel && s1_apb_psel) ? ~last_grant : s1_apb_psel;
        g_psel      = last_grant ? s1_apb_psel : s0_apb_psel;
        g_penable   = last_grant ? s1_apb_penable : s0_apb_penable;
        timeout_hit = (G_TIMEOUT != 0) && (to_cnt == TO_LAST);
        state_nxt   = state;
        do_grant    = 1'b0;
        do_capture  = 1'b0;
        do_timeout  = 1'b0;
        rsp_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s0_apb_psel || s1_apb_psel) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (m_apb_pready) begin
                    do_capture = 1'b1;
                    state_nxt  = ST_RESP;
                end else if (timeout_hit) begin
                    do_timeout = 1'b1;
                    state_nxt  = ST_RESP;
                end
            end
            ST_RESP: begin
                // A granted requester that abandons its transfer forfeits the response
                if (!g_psel) begin
                    state_nxt = ST_IDLE;
                end else if (g_penable) begin
                    rsp_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer; last_grant=1 so port 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (do_grant) begin
                last_grant <= grant_sel;
            end
        end
    end

    // Request latch, timeout counter and captured response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_pwrite  <= 1'b0;
            lat_pprot   <= '0;
            lat_paddr   <= '0;
            lat_pwdata  <= '0;
            lat_pstrb   <= '0;
            rsp_prdata  <= '0;
            rsp_pslverr <= 1'b0;
            to_cnt      <= '0;
        end else begin
            if (do_grant) begin
                lat_pwrite <= grant_sel ? s1_apb_pwrite : s0_apb_pwrite;
                lat_pprot  <= grant_sel ? s1_apb_pprot  : s0_apb_pprot;
                lat_paddr  <= grant_sel ? s1_apb_paddr  : s0_apb_paddr;
                lat_pwdata <= grant_sel ? s1_apb_pwdata : s0_apb_pwdata;
                lat_pstrb  <= grant_sel ? s1_apb_pstrb  : s0_apb_pstrb;
                to_cnt     <= '0;
            end else if (state == ST_ACCESS) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (do_capture) begin
                rsp_prdata  <= lat_pwrite ? 32'h0 : m_apb_prdata;
                rsp_pslverr <= m_apb_pslverr;
            end else if (do_timeout) begin
                rsp_prdata  <= 32'h0;
                rsp_pslverr <= 1'b1;
            end
        end
    end

    assign m_active       = (state == ST_SETUP) || (state == ST_ACCESS);
    assign m_apb_psel     = m_active;
    assign m_apb_penable  = (state == ST_ACCESS);
    assign m_apb_pwrite   = m_active & lat_pwrite;
    assign m_apb_pprot    = m_active ? lat_pprot  : '0;
    assign m_apb_paddr    = m_active ? lat_paddr  : '0;
    assign m_apb_pwdata   = m_active ? lat_pwdata : '0;
    assign m_apb_pstrb    = m_active ? lat_pstrb  : '0;

    assign s0_apb_pready  = rsp_fire & ~last_grant;
    assign s1_apb_pready  = rsp_fire & last_grant;
    assign s0_apb_prdata  = s0_apb_pready ? rsp_prdata : '0;
    assign s1_apb_prdata  = s1_apb_pready ? rsp_prdata : '0;
    assign s0_apb_pslverr = s0_apb_pready & rsp_pslverr;
    assign s1_apb_pslverr = s1_apb_pready & rsp_pslverr;
endmodule
